// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller poll scheduler.
// Button indices, the D-pad mask and the scheduler state encoding.
package nes_pkg;

   localparam int NES_BTN_W = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam logic [NES_BTN_W-1:0] DPAD_MASK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRIGGER,
      ST_SCAN,
      ST_CAPTURE
   } nes_state_t;

endpackage

// File: rtl/nes_repeat_timer.sv
// Hold counter for one D-pad button, producing auto-repeat events.
// Advances only on capture cycles; fire is valid while step is high.
module nes_repeat_timer #(
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 6
)(
   input  logic clock,
   input  logic reset,
   input  logic step,
   input  logic held,
   input  logic press,
   output logic fire
);

   localparam int CW = $clog2(REPEAT_DELAY + 1);

   logic [CW-1:0] hc;
   logic [CW-1:0] nxt;
   logic          hit;

   assign nxt  = hc + 1'b1;
   assign hit  = (nxt == CW'(REPEAT_DELAY));
   assign fire = step && held && !press && hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         hc <= '0;
      end else if (step) begin
         if (!held || press)
            hc <= '0;
         else if (hit)
            hc <= CW'(REPEAT_DELAY - REPEAT_RATE);
         else
            hc <= nxt;
      end
   end

endmodule

// File: rtl/nes_poll_scheduler.sv
// Polls the NES controller interface at a fixed rate and turns each
// button sample into an event frame handed to game logic via valid/ack.
module nes_poll_scheduler
   import nes_pkg::*;
#(
   parameter int POLL_PERIOD  = 833_333,
   parameter int SCAN_CYCLES  = 5200,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 6
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 run,
   output logic                 nes_enable,
   input  logic [NES_BTN_W-1:0] player_input,
   output logic [NES_BTN_W-1:0] buttons,
   output logic [NES_BTN_W-1:0] pressed,
   output logic [NES_BTN_W-1:0] released,
   output logic [3:0]           repeat_evt,
   output logic                 frame_valid,
   input  logic                 frame_ack,
   output logic                 overrun
);

   localparam int PW = $clog2(POLL_PERIOD);
   localparam int SW = $clog2(SCAN_CYCLES);

   nes_state_t           state;
   logic [PW-1:0]        period_cnt;
   logic [SW-1:0]        scan_cnt;
   logic                 capture;
   logic [NES_BTN_W-1:0] s;
   logic [NES_BTN_W-1:0] pn;
   logic [NES_BTN_W-1:0] rn;
   logic [3:0]           rp;

   assign capture = (state == ST_CAPTURE);
   assign s       = player_input;
   assign pn      = s & ~buttons;
   assign rn      = ~s & buttons;

   always_ff @(posedge clock) begin
      if (reset || !run)
         period_cnt <= '0;
      else if (period_cnt == PW'(POLL_PERIOD - 1))
         period_cnt <= '0;
      else
         period_cnt <= period_cnt + 1'b1;
   end

   // nes_enable is raised on entry to TRIGGER so it is high only there
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         scan_cnt   <= '0;
         nes_enable <= 1'b0;
      end else begin
         nes_enable <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (run && period_cnt == '0) begin
                  state      <= ST_TRIGGER;
                  nes_enable <= 1'b1;
               end
            end
            ST_TRIGGER: begin
               state    <= ST_SCAN;
               scan_cnt <= '0;
            end
            ST_SCAN: begin
               scan_cnt <= scan_cnt + 1'b1;
               if (scan_cnt == SW'(SCAN_CYCLES - 1))
                  state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_rep
      nes_repeat_timer #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_rep (
         .clock (clock),
         .reset (reset),
         .step  (capture),
         .held  (s[BTN_UP + i]),
         .press (pn[BTN_UP + i]),
         .fire  (rp[i])
      );
   end

   // an unacknowledged frame absorbs new events and flags the overrun
   always_ff @(posedge clock) begin
      if (reset) begin
         buttons     <= '0;
         pressed     <= '0;
         released    <= '0;
         repeat_evt  <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else if (capture) begin
         buttons     <= s;
         frame_valid <= 1'b1;
         if (!frame_valid || frame_ack) begin
            pressed    <= pn;
            released   <= rn;
            repeat_evt <= rp;
            overrun    <= 1'b0;
         end else begin
            pressed    <= pressed | pn;
            released   <= released | rn;
            repeat_evt <= repeat_evt | rp;
            overrun    <= 1'b1;
         end
      end else if (frame_valid && frame_ack) begin
         pressed     <= '0;
         released    <= '0;
         repeat_evt  <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Scoreboard bench for nes_poll_scheduler with a behavioural controller.
module tb_nes_poll_scheduler;

   localparam int PP = 8000;
   localparam int SC = 5200;
   localparam int RD = 3;
   localparam int RR = 1;

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] p;
      logic [7:0] r;
      logic [3:0] rep;
      logic       fv;
      logic       ov;
   } frame_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       run;
   logic       nes_enable;
   logic [7:0] player_input;
   logic [7:0] buttons;
   logic [7:0] pressed;
   logic [7:0] released;
   logic [3:0] repeat_evt;
   logic       frame_valid;
   logic       frame_ack;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_en = 0;

   logic [7:0] mb, mp, mr;
   logic [3:0] mrep;
   logic       mfv, mov;
   int         hc [4];
   frame_t     exp_q [$];

   nes_poll_scheduler #(
      .POLL_PERIOD  (PP),
      .SCAN_CYCLES  (SC),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .run          (run),
      .nes_enable   (nes_enable),
      .player_input (player_input),
      .buttons      (buttons),
      .pressed      (pressed),
      .released     (released),
      .repeat_evt   (repeat_evt),
      .frame_valid  (frame_valid),
      .frame_ack    (frame_ack),
      .overrun      (overrun)
   );

   always #10 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mb = 0; mp = 0; mr = 0; mrep = 0; mfv = 0; mov = 0;
      for (int i = 0; i < 4; i++) hc[i] = 0;
   endtask

   task automatic model_capture(input logic [7:0] sv, input bit a);
      logic [7:0] pn, rn;
      logic [3:0] rp;
      pn = sv & ~mb;
      rn = ~sv & mb;
      rp = 0;
      for (int i = 0; i < 4; i++) begin
         if (!sv[4+i] || pn[4+i]) hc[i] = 0;
         else if (hc[i] + 1 == RD) begin
            rp[i] = 1'b1;
            hc[i] = RD - RR;
         end else hc[i] = hc[i] + 1;
      end
      if (!mfv || a) begin
         mp = pn; mr = rn; mrep = rp; mov = 0;
      end else begin
         mp |= pn; mr |= rn; mrep |= rp; mov = 1;
      end
      mfv = 1;
      mb = sv;
   endtask

   task automatic model_ack();
      if (mfv) begin
         mp = 0; mr = 0; mrep = 0; mfv = 0; mov = 0;
      end
   endtask

   task automatic check_frame(input frame_t e);
      check("buttons", buttons, e.b);
      check("pressed", pressed, e.p);
      check("released", released, e.r);
      check("repeat_evt", repeat_evt, e.rep);
      check("frame_valid", frame_valid, e.fv);
      check("overrun", overrun, e.ov);
   endtask

   // controller model presents pad for the whole scan of the next poll
   task automatic poll(input logic [7:0] pad, input bit ack_after,
                       input bit ack_same, input bit drop_run,
                       input bit gap_chk);
      int n;
      frame_t e;
      n = 0;
      while (!nes_enable && n < 20000) begin
         @(negedge clock);
         n++;
      end
      if (!nes_enable) begin
         check("en_timeout", nes_enable, 1);
         return;
      end
      if (gap_chk) check("poll_gap", cyc - last_en, PP);
      last_en = cyc;
      player_input = pad;
      model_capture(pad, ack_same);
      exp_q.push_back('{mb, mp, mr, mrep, mfv, mov});
      @(negedge clock);
      check("en_width", nes_enable, 0);
      n = 1;
      if (drop_run) begin
         repeat (100) @(negedge clock);
         run = 1'b0;
         n += 100;
      end
      while (n < SC + 1) begin
         @(negedge clock);
         n++;
      end
      if (ack_same) frame_ack = 1'b1;
      @(negedge clock);
      frame_ack = 1'b0;
      e = exp_q.pop_front();
      check_frame(e);
      if (ack_after) begin
         frame_ack = 1'b1;
         @(negedge clock);
         frame_ack = 1'b0;
         model_ack();
         check_frame('{mb, mp, mr, mrep, mfv, mov});
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b1;
      run = 1'b1;
      frame_ack = 1'b0;
      player_input = 8'h00;
      model_reset();
      repeat (3) @(negedge clock);
      check("rst_en", nes_enable, 0);
      check_frame('{8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0});
      reset = 1'b0;
      @(negedge clock);
      check("first_en", nes_enable, 1);

      poll(8'h01, 1, 0, 0, 0);
      check("first_pressed", pressed, 8'h00);

      for (int i = 0; i < 4; i++) poll(8'h10, 1, 0, 0, 1);
      poll(8'h00, 1, 0, 0, 1);

      poll(8'h01, 0, 0, 0, 1);
      poll(8'h03, 1, 0, 0, 1);

      poll(8'h04, 0, 0, 0, 1);
      poll(8'h08, 0, 1, 0, 1);

      poll(8'h80, 1, 0, 1, 1);
      cnt = 0;
      repeat (3800) begin
         @(negedge clock);
         if (nes_enable) cnt++;
      end
      check("no_en_after_stop", cnt, 0);

      run = 1'b1;
      cnt = 0;
      while (!nes_enable && cnt < 20000) begin
         @(negedge clock);
         cnt++;
      end
      check("restart_en", nes_enable, 1);
      repeat (100) @(negedge clock);
      reset = 1'b1;
      run = 1'b0;
      @(negedge clock);
      check("midscan_rst_en", nes_enable, 0);
      check_frame('{8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0});
      reset = 1'b0;
      model_reset();
      cnt = 0;
      repeat (SC + 200) begin
         @(negedge clock);
         if (frame_valid || nes_enable) cnt++;
      end
      check("aborted_scan", cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
